// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file target: FSM encoding,
// field widths and the fixed address/bit positions of the command byte.
package spi_pkg;

  localparam int SPI_ADDR_W     = 3;
  localparam int SPI_DATA_W     = 8;
  localparam int SPI_RO_ADDR    = 7;
  localparam int SPI_WR_BIT     = 7;
  localparam int SPI_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  // Address 7 is the read-only status slot backed by data_in.
  function automatic logic is_ro_addr(input logic [SPI_ADDR_W-1:0] addr);
    return addr == SPI_ADDR_W'(SPI_RO_ADDR);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses. The reinit
// input suppresses any edge in that clk and lets the history flop track
// the current level, so a mode change while deselected never looks like
// an SCK edge once the frame starts.
module spi_sync_edge #(
  parameter int   N_SYNC  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic reinit,
  output logic rise,
  output logic fall
);

  logic [N_SYNC-1:0] sync_q;
  logic              prev_q;
  logic              level;

  assign level = sync_q[N_SYNC-1];

  // Synchronizer chain, one-clk history and registered edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {N_SYNC{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[N_SYNC-2:0], din};
      prev_q <= level;
      rise   <= ~reinit & level & ~prev_q;
      fall   <= ~reinit & ~level & prev_q;
    end
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI target with a 7-entry register file plus a read-only status slot.
// Frame = command byte (bit7 write flag, bits2:0 address) + data byte.
// SCK/SS/MOSI are oversampled in clk; all decisions are made on the
// registered edge pulses from spi_sync_edge.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int N_SYNC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CKP,
  input  logic                  CPH,
  input  logic                  SS,
  input  logic                  SCK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [SPI_DATA_W-1:0] data_in,
  output logic [SPI_DATA_W-1:0] ctrl_out,
  output logic                  wr_strb,
  output logic [SPI_ADDR_W-1:0] wr_addr,
  output logic [SPI_DATA_W-1:0] wr_data
);

  spi_state_e            state_q, state_d;
  logic [4:0]            bit_cnt;
  logic [SPI_DATA_W-1:0] rx_sr;
  logic [SPI_DATA_W-1:0] tx_sr;
  logic [SPI_DATA_W-1:0] rx_next;
  logic                  cmd_wr;
  logic [SPI_ADDR_W-1:0] cmd_addr;
  logic [SPI_DATA_W-1:0] regs [8];

  logic                  sck_rise, sck_fall, ss_rise, ss_fall;
  logic [N_SYNC-1:0]     mosi_sync;
  logic                  mosi_s;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  sample_active, shift_active, cmd_done, data_done;

  // SS resets to the low level: after rst with SS still low no fall can be
  // seen, so the remainder of an interrupted frame is ignored until SS has
  // gone high and falls again.
  spi_sync_edge #(.N_SYNC(N_SYNC), .RST_VAL(1'b0)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (SS),
    .reinit (1'b0),
    .rise   (ss_rise),
    .fall   (ss_fall)
  );

  spi_sync_edge #(.N_SYNC(N_SYNC), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (SCK),
    .reinit (ss_fall),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  // MOSI only needs level synchronization; it is stable around sample edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[N_SYNC-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[N_SYNC-1];

  // Edge roles from polarity and phase.
  assign lead_edge   = CKP ? sck_fall : sck_rise;
  assign trail_edge  = CKP ? sck_rise : sck_fall;
  assign sample_edge = CPH ? trail_edge : lead_edge;
  assign shift_edge  = CPH ? lead_edge : trail_edge;

  assign sample_active = sample_edge && (state_q == ST_CMD || state_q == ST_DATA);
  assign cmd_done      = sample_active && (state_q == ST_CMD)  && (bit_cnt == 5'd7);
  assign data_done     = sample_active && (state_q == ST_DATA) && (bit_cnt == 5'(SPI_FRAME_BITS - 1));
  // The MSB is preloaded on entering DATA, so the first shift edge that
  // follows (bit_cnt still 8) must not move it.
  assign shift_active  = shift_edge && (state_q == ST_DATA) && (bit_cnt != 5'd8);
  assign rx_next       = {rx_sr[SPI_DATA_W-2:0], mosi_s};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; SS rise wins from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall)   state_d = ST_CMD;
      ST_CMD:  if (cmd_done)  state_d = ST_DATA;
      ST_DATA: if (data_done) state_d = ST_DONE;
      default: state_d = state_q;
    endcase
    if (ss_rise) state_d = ST_IDLE;
  end

  // Bit counter, shift registers, command latch and register-file commit.
  // A commit coinciding with SS rise still happens: data_done ignores SS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      cmd_wr   <= 1'b0;
      cmd_addr <= '0;
      wr_strb  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      wr_strb <= 1'b0;

      if (ss_fall || ss_rise)  bit_cnt <= '0;
      else if (sample_active)  bit_cnt <= bit_cnt + 5'd1;

      if (sample_active) rx_sr <= rx_next;

      if (ss_fall) begin
        tx_sr <= '0;
      end else if (cmd_done) begin
        cmd_wr   <= rx_next[SPI_WR_BIT];
        cmd_addr <= rx_next[SPI_ADDR_W-1:0];
        if (rx_next[SPI_WR_BIT])                      tx_sr <= '0;
        else if (is_ro_addr(rx_next[SPI_ADDR_W-1:0])) tx_sr <= data_in;
        else                                          tx_sr <= regs[rx_next[SPI_ADDR_W-1:0]];
      end else if (shift_active) begin
        tx_sr <= {tx_sr[SPI_DATA_W-2:0], 1'b0};
      end

      if (data_done && cmd_wr && !is_ro_addr(cmd_addr)) begin
        regs[cmd_addr] <= rx_next;
        wr_strb        <= 1'b1;
        wr_addr        <= cmd_addr;
        wr_data        <= rx_next;
      end
    end
  end

  assign MISO     = (state_q == ST_DATA) ? tx_sr[SPI_DATA_W-1] : 1'b0;
  assign ctrl_out = regs[0];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: bit-level SPI master in all four modes,
// a reference register model, a write-strobe scoreboard and per-frame
// MISO comparison.
module tb_spi_slave_regfile;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CKP = 1'b0;
  logic       CPH = 1'b0;
  logic       SS = 1'b1;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [7:0] data_in = 8'h00;
  logic [7:0] ctrl_out;
  logic       wr_strb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  int          total = 0;
  int          bad = 0;
  logic [10:0] exp_q[$];
  logic [23:0] rx_q[$];
  logic [7:0]  model [8];
  logic [10:0] last_wr = '0;
  logic        strb_prev = 1'b0;

  spi_slave_regfile #(.N_SYNC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .CKP      (CKP),
    .CPH      (CPH),
    .SS       (SS),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .data_in  (data_in),
    .ctrl_out (ctrl_out),
    .wr_strb  (wr_strb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Write-strobe scoreboard: every strobe must be a single clk and match
  // the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && wr_strb) begin
      logic [10:0] exp_w;
      total = total + 1;
      if (strb_prev) begin
        bad = bad + 1;
        $display("FAIL strb_width: wr_strb high for more than one clk");
      end else if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_strb: got addr=%0d data=%02h, none expected", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          bad = bad + 1;
          $display("FAIL strb_payload: got addr=%0d data=%02h, want addr=%0d data=%02h",
                   wr_addr, wr_data, exp_w[10:8], exp_w[7:0]);
        end
      end
    end
    strb_prev = wr_strb;
  end

  // Bit-level master. rst_at >= 0 pulses rst just before that bit.
  task automatic spi_frame(input logic [23:0] tx, input int nbits, input int rst_at,
                           output logic [23:0] rx);
    rx = '0;
    @(negedge clk);
    SCK  = CKP;
    MOSI = 1'b0;
    repeat (8) @(negedge clk);
    SS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        total = total + 5;
        if (MISO !== 1'b0)      begin bad = bad + 1; $display("FAIL rst_miso: got %b want 0", MISO); end
        if (ctrl_out !== 8'h00) begin bad = bad + 1; $display("FAIL rst_ctrl: got %02h want 00", ctrl_out); end
        if (wr_strb !== 1'b0)   begin bad = bad + 1; $display("FAIL rst_strb: got %b want 0", wr_strb); end
        if (wr_addr !== 3'd0)   begin bad = bad + 1; $display("FAIL rst_waddr: got %0d want 0", wr_addr); end
        if (wr_data !== 8'h00)  begin bad = bad + 1; $display("FAIL rst_wdata: got %02h want 00", wr_data); end
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) model[r] = 8'h00;
        last_wr = '0;
        exp_q.delete();
      end
      if (!CPH) begin
        MOSI = tx[23-i];
        repeat (HALF) @(negedge clk);
        SCK = ~CKP;
        rx[23-i] = MISO;
        repeat (HALF) @(negedge clk);
        SCK = CKP;
      end else begin
        SCK  = ~CKP;
        MOSI = tx[23-i];
        repeat (HALF) @(negedge clk);
        SCK = CKP;
        rx[23-i] = MISO;
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
    SS   = 1'b1;
    MOSI = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // One transaction: predicts MISO and any commit, runs the frame, compares.
  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                        input int rst_at);
    logic [23:0] rx;
    logic [23:0] exp_rx;
    logic [7:0]  rd;
    rd = 8'h00;
    if (!cmd[7] && nbits >= 16) rd = (cmd[2:0] == 3'd7) ? data_in : model[cmd[2:0]];
    rx_q.push_back({8'h00, rd, 8'h00});
    if (nbits >= 16 && rst_at < 0 && cmd[7] && cmd[2:0] != 3'd7) begin
      exp_q.push_back({cmd[2:0], dat});
      model[cmd[2:0]] = dat;
      last_wr = {cmd[2:0], dat};
    end
    spi_frame({cmd, dat, 8'hFF}, nbits, rst_at, rx);
    exp_rx = rx_q.pop_front();
    total = total + 1;
    if (rx !== exp_rx) begin
      bad = bad + 1;
      $display("FAIL miso cmd=%02h mode=%b%b: got %06h want %06h", cmd, CKP, CPH, rx, exp_rx);
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL strb_missing cmd=%02h: %0d commit(s) not seen", cmd, exp_q.size());
      exp_q.delete();
    end
    total = total + 1;
    if ({wr_addr, wr_data} !== last_wr) begin
      bad = bad + 1;
      $display("FAIL wr_hold cmd=%02h: got addr=%0d data=%02h want addr=%0d data=%02h",
               cmd, wr_addr, wr_data, last_wr[10:8], last_wr[7:0]);
    end
    total = total + 1;
    if (ctrl_out !== model[0]) begin
      bad = bad + 1;
      $display("FAIL ctrl_out cmd=%02h: got %02h want %02h", cmd, ctrl_out, model[0]);
    end
  endtask

  task automatic test_reset();
    for (int r = 0; r < 8; r++) model[r] = 8'h00;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total = total + 5;
    if (MISO !== 1'b0)      begin bad = bad + 1; $display("FAIL reset_miso: got %b want 0", MISO); end
    if (ctrl_out !== 8'h00) begin bad = bad + 1; $display("FAIL reset_ctrl: got %02h want 00", ctrl_out); end
    if (wr_strb !== 1'b0)   begin bad = bad + 1; $display("FAIL reset_strb: got %b want 0", wr_strb); end
    if (wr_addr !== 3'd0)   begin bad = bad + 1; $display("FAIL reset_waddr: got %0d want 0", wr_addr); end
    if (wr_data !== 8'h00)  begin bad = bad + 1; $display("FAIL reset_wdata: got %02h want 00", wr_data); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write_mode10();
    CKP = 1'b1; CPH = 1'b0;
    do_txn(8'h82, 8'h55, 16, -1);
  endtask

  task automatic test_readback_mode01();
    CKP = 1'b0; CPH = 1'b1;
    do_txn(8'h80, 8'hA5, 16, -1);
    do_txn(8'h00, 8'h00, 16, -1);
  endtask

  task automatic test_ro_all_modes();
    data_in = 8'h3C;
    for (int m = 0; m < 4; m++) begin
      CKP = m[1]; CPH = m[0];
      do_txn(8'h07, 8'h00, 16, -1);
    end
  endtask

  task automatic test_ro_write();
    CKP = 1'b0; CPH = 1'b0;
    data_in = 8'h5A;
    do_txn(8'h87, 8'hFF, 16, -1);
    do_txn(8'h07, 8'h00, 16, -1);
  endtask

  task automatic test_abort();
    CKP = 1'b1; CPH = 1'b1;
    do_txn(8'h81, 8'h99, 12, -1);
    do_txn(8'h01, 8'h00, 16, -1);
    do_txn(8'h81, 8'h6B, 16, -1);
    do_txn(8'h01, 8'h00, 16, -1);
  endtask

  task automatic test_reset_mid();
    CKP = 1'b0; CPH = 1'b0;
    do_txn(8'h83, 8'h77, 16, 12);
    do_txn(8'h00, 8'h00, 16, -1);
    do_txn(8'h03, 8'h00, 16, -1);
  endtask

  task automatic test_long_frame();
    CKP = 1'b1; CPH = 1'b0;
    do_txn(8'h84, 8'h3A, 24, -1);
    CKP = 1'b0; CPH = 1'b1;
    do_txn(8'h04, 8'h00, 24, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] cmd;
      CKP = 1'($urandom_range(0, 1));
      CPH = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      cmd = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
      do_txn(cmd, 8'($urandom_range(0, 255)), 16, -1);
    end
  endtask

  initial begin
    test_reset();
    test_write_mode10();
    test_readback_mode01();
    test_ro_all_modes();
    test_ro_write();
    test_abort();
    test_reset_mid();
    test_long_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
